reaction_stats: RTL and testbench

Statistics stage downstream of the reaction-time counter. It captures each completed 14-bit millisecond reaction time and keeps the last result, the best (minimum) result, a sample count and the mean of the last eight results. It then drives one selected value into the 16-bit binary-to-BCD converter for the seven-segment display. A new-best pulse is provided for an LED.

---
 rtl/reaction_pkg.sv | 24 ++
 rtl/seq_divider.sv | 88 ++++++++
 rtl/reaction_stats.sv | 110 +++++++++++
 tb/tb_reaction_stats.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared constants and types for the reaction-time statistics stage.
package reaction_pkg;

   localparam int TIME_W   = 14;     // reaction time in ms
   localparam int MAX_TIME = 9999;   // largest value the 4-digit display can show
   localparam int DEPTH    = 8;      // history entries, power of two
   localparam int SUM_W    = 17;     // 8 * 9999 = 79992 fits without overflow
   localparam int COUNT_W  = 4;      // sample count, saturates at DEPTH

   // Display select encodings driven by the user switches.
   typedef enum logic [1:0] {
      SEL_LAST  = 2'd0,
      SEL_BEST  = 2'd1,
      SEL_AVG   = 2'd2,
      SEL_COUNT = 2'd3
   } disp_sel_e;

   // Divider control states.
   typedef enum logic {
      DIV_IDLE = 1'b0,
      DIV_RUN  = 1'b1
   } div_state_e;

endpackage

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, DIVIDEND_W cycles.
// The final quotient is presented combinationally on the cycle done is high,
// so the consumer captures it on the same edge the last iteration completes.
module seq_divider
   import reaction_pkg::*;
#(
   parameter int DIVIDEND_W = SUM_W,
   parameter int DIVISOR_W  = COUNT_W,
   parameter int QUOT_W     = TIME_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic [QUOT_W-1:0]     quotient,
   output logic                  busy,
   output logic                  done
);

   localparam int CNT_W = $clog2(DIVIDEND_W);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIVIDEND_W - 1);

   div_state_e             state, state_next;
   logic [DIVIDEND_W-1:0]  quo, quo_next;
   logic [DIVISOR_W-1:0]   rem, rem_next, dvsr;
   logic [DIVISOR_W:0]     rem_shift;
   logic                   ge;
   logic [CNT_W-1:0]       iter;

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   // The remainder stays below the divisor, so the low bits of the difference
   // are exact and the shifted value's top bit only matters for the compare.
   assign rem_shift = {rem, quo[DIVIDEND_W-1]};
   assign ge        = (rem_shift >= {1'b0, dvsr});
   assign rem_next  = ge ? (rem_shift[DIVISOR_W-1:0] - dvsr) : rem_shift[DIVISOR_W-1:0];
   assign quo_next  = {quo[DIVIDEND_W-2:0], ge};
   assign quotient  = quo_next[QUOT_W-1:0];

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= DIV_IDLE;
      else       state <= state_next;
   end

   // Next state: abort beats everything, start (re)enters the run state.
   always_comb begin
      // NOTE: assigning a default before the case means every path drives the
      // signal, so no latch is inferred when a branch leaves it unassigned.
      state_next = state;
      case (state)
         DIV_IDLE: if (start && !abort) state_next = DIV_RUN;
         DIV_RUN: begin
            if (abort)                   state_next = DIV_IDLE;
            else if (start)              state_next = DIV_RUN;
            else if (iter == LAST_ITER)  state_next = DIV_IDLE;
         end
         default: state_next = DIV_IDLE;
      endcase
   end

   // Outputs: done marks the final iteration unless it is being cancelled.
   always_comb begin
      busy = (state == DIV_RUN);
      done = (state == DIV_RUN) && (iter == LAST_ITER) && !start && !abort;
   end

   // Datapath: load operands on start, otherwise iterate while running.
   always_ff @(posedge clk) begin
      if (reset) begin
         quo  <= '0;
         rem  <= '0;
         dvsr <= '0;
         iter <= '0;
      end else if (start) begin
         quo  <= dividend;
         rem  <= '0;
         dvsr <= divisor;
         iter <= '0;
      end else if (state == DIV_RUN) begin
         quo  <= quo_next;
         rem  <= rem_next;
         iter <= iter + CNT_W'(1);
      end
   end

endmodule

// File: rtl/reaction_stats.sv
// Reaction-time statistics: last, best, sample count and the mean of the most
// recent DEPTH results, with one value selected for the BCD display.
module reaction_stats
   import reaction_pkg::*;
(
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic               clear,
   input  logic               time_valid,
   input  logic [TIME_W-1:0]  time_in,
   input  logic [1:0]         sel,
   output logic [TIME_W-1:0]  disp_value,
   output logic [TIME_W-1:0]  best,
   output logic [TIME_W-1:0]  avg,
   output logic [COUNT_W-1:0] count,
   output logic               avg_busy,
   output logic               new_best
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [TIME_W-1:0]  MAX_T = TIME_W'(MAX_TIME);
   localparam logic [COUNT_W-1:0] FULL  = COUNT_W'(DEPTH);

   logic [TIME_W-1:0] hist [DEPTH];
   logic [TIME_W-1:0] last;
   logic [TIME_W-1:0] t_sat;
   logic [SUM_W-1:0]  sum;
   logic [PTR_W-1:0]  wptr;
   logic              best_valid;
   logic              is_new_best;
   logic              start_div;
   logic              div_done;
   logic [TIME_W-1:0] div_quotient;
   logic              wipe;

   assign wipe        = reset || clear;
   assign t_sat       = (time_in > MAX_T) ? MAX_T : time_in;
   assign is_new_best = !best_valid || (t_sat < best);

   // Sample capture: last, best, ring buffer, running sum and count.
   always_ff @(posedge CLOCK_50) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // here samples the pre-edge values, e.g. sum reads the old hist[wptr].
      if (wipe) begin
         last       <= '0;
         best       <= MAX_T;
         best_valid <= 1'b0;
         count      <= '0;
         sum        <= '0;
         wptr       <= '0;
         new_best   <= 1'b0;
         start_div  <= 1'b0;
         // NOTE: the history is cleared explicitly because the running sum
         // subtracts the evicted entry even before the buffer has filled.
         for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
      end else begin
         new_best  <= 1'b0;
         start_div <= time_valid;
         if (time_valid) begin
            last       <= t_sat;
            hist[wptr] <= t_sat;
            sum        <= sum + SUM_W'(t_sat) - SUM_W'(hist[wptr]);
            wptr       <= wptr + PTR_W'(1);
            if (count != FULL) count <= count + COUNT_W'(1);
            if (is_new_best) begin
               best       <= t_sat;
               best_valid <= 1'b1;
               new_best   <= 1'b1;
            end
         end
      end
   end

   // Mean of the history; started the cycle after an accept so it sees the
   // updated sum and count. clear aborts a division in flight.
   seq_divider #(
      .DIVIDEND_W (SUM_W),
      .DIVISOR_W  (COUNT_W),
      .QUOT_W     (TIME_W)
   ) u_div (
      .clk      (CLOCK_50),
      .reset    (reset),
      .start    (start_div),
      .abort    (clear),
      .dividend (sum),
      .divisor  (count),
      .quotient (div_quotient),
      .busy     (avg_busy),
      .done     (div_done)
   );

   // Average register: holds the previous mean until a division completes.
   always_ff @(posedge CLOCK_50) begin
      if (wipe)          avg <= '0;
      else if (div_done) avg <= div_quotient;
   end

   // Display select, no latency.
   always_comb begin
      disp_value = '0;
      case (disp_sel_e'(sel))
         SEL_LAST:  disp_value = last;
         SEL_BEST:  disp_value = best_valid ? best : '0;
         SEL_AVG:   disp_value = avg;
         SEL_COUNT: disp_value = TIME_W'(count);
         default:   disp_value = '0;
      endcase
   end

endmodule

// File: tb/tb_reaction_stats.sv
// Scoreboard bench for reaction_stats: the driver computes expected results
// from a queue-based model of the history and pushes them; a negedge monitor
// pops and compares when the DUT presents them.
module tb_reaction_stats;
   import reaction_pkg::*;

   logic               CLOCK_50 = 1'b0;
   logic               reset, clear, time_valid;
   logic [TIME_W-1:0]  time_in;
   logic [1:0]         sel;
   logic [TIME_W-1:0]  disp_value, best, avg;
   logic [COUNT_W-1:0] count;
   logic               avg_busy, new_best;

   reaction_stats dut (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .clear      (clear),
      .time_valid (time_valid),
      .time_in    (time_in),
      .sel        (sel),
      .disp_value (disp_value),
      .best       (best),
      .avg        (avg),
      .count      (count),
      .avg_busy   (avg_busy),
      .new_best   (new_best)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int cyc = 0;
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   int passed = 0;
   int total  = 0;

   task automatic check(input string name, input int actual, input int expected);
      total++;
      if (actual == expected) passed++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
   endtask

   // Expected per-sample state (due = cycle count when it becomes visible)
   typedef struct { int due; int last; int best; int count; bit nb; } samp_t;
   // Expected average write: cycle it is visible, first busy cycle, value
   typedef struct { int due; int start; int avg; } avg_t;

   samp_t samp_q[$];
   avg_t  avg_q[$];

   // Reference model: recent results as a plain queue
   int hist_q[$];
   int m_last, m_best, m_avg;
   bit m_best_valid;

   task automatic model_clear();
      hist_q.delete();
      m_last = 0;
      m_best = MAX_TIME;
      m_best_valid = 1'b0;
      m_avg = 0;
   endtask

   // Issue one sample, then idle so the next sample lands gap edges later.
   task automatic send(input int t, input int gap);
      int n, tc, s, st;
      samp_t e;
      avg_t a;
      n  = cyc + 1;
      tc = (t > MAX_TIME) ? MAX_TIME : t;
      hist_q.push_back(tc);
      if (hist_q.size() > DEPTH) void'(hist_q.pop_front());
      e.nb = !m_best_valid || (tc < m_best);
      if (e.nb) begin
         m_best = tc;
         m_best_valid = 1'b1;
      end
      m_last = tc;
      s = 0;
      foreach (hist_q[i]) s += hist_q[i];
      m_avg = s / hist_q.size();
      e.due = n; e.last = tc; e.best = m_best; e.count = hist_q.size();
      samp_q.push_back(e);
      // A division whose result is not yet written gets superseded.
      st = n + 1;
      if (avg_q.size() > 0 && avg_q[$].due > n) begin
         st = avg_q[$].start;
         void'(avg_q.pop_back());
      end
      a.due = n + 18; a.start = st; a.avg = m_avg;
      avg_q.push_back(a);
      time_valid = 1'b1;
      time_in    = TIME_W'(t);
      @(posedge CLOCK_50); #1;
      time_valid = 1'b0;
      for (int i = 1; i < gap; i++) begin
         @(posedge CLOCK_50); #1;
      end
   endtask

   // One-cycle clear, optionally with a colliding sample that must be dropped.
   task automatic do_clear(input bit with_tv, input int t);
      int c;
      c = cyc + 1;
      clear      = 1'b1;
      time_valid = with_tv;
      time_in    = TIME_W'(t);
      model_clear();
      while (avg_q.size() > 0 && avg_q[$].due >= c) void'(avg_q.pop_back());
      @(posedge CLOCK_50); #1;
      clear      = 1'b0;
      time_valid = 1'b0;
   endtask

   // Monitor
   bit                mon_en = 1'b0;
   bit                clr_q  = 1'b0;
   logic              prev_busy = 1'b0;
   logic [TIME_W-1:0] prev_avg  = '0;
   int                run = 0;

   always @(negedge CLOCK_50) begin : monitor
      bit    cleared;
      samp_t e;
      avg_t  a;
      if (mon_en) begin
         cleared = clr_q;
         clr_q   = reset || clear;
         if (avg_busy) run++;
         if (cleared) begin
            check("clr_avg",      avg,        0);
            check("clr_busy",     avg_busy,   0);
            check("clr_count",    count,      0);
            check("clr_best",     best,       MAX_TIME);
            check("clr_new_best", new_best,   0);
            check("clr_disp",     disp_value, 0);
            run = 0;
         end else if (prev_busy && !avg_busy) begin
            check("avg_write_expected", int'(avg_q.size() > 0), 1);
            if (avg_q.size() > 0) begin
               a = avg_q.pop_front();
               check("avg_value",    avg,  a.avg);
               check("avg_cycle",    cyc,  a.due);
               check("avg_busy_len", run,  a.due - a.start);
            end
            run = 0;
         end else if (avg != prev_avg) begin
            check("avg_hold", avg, prev_avg);
         end
         if (samp_q.size() > 0 && samp_q[0].due == cyc) begin
            e = samp_q.pop_front();
            check("count",    count,    e.count);
            check("best",     best,     e.best);
            check("new_best", new_best, e.nb);
            if (sel == 2'd0) check("last", disp_value, e.last);
         end else if (new_best) begin
            check("new_best_spurious", new_best, 0);
         end
         prev_busy = avg_busy;
         prev_avg  = avg;
      end
   end

   // Stimulus
   int exp_sweep [4];
   int r, t;

   initial begin
      reset = 1'b1; clear = 1'b0; time_valid = 1'b0; time_in = '0; sel = 2'd0;
      model_clear();
      @(posedge CLOCK_50); #1;
      mon_en = 1'b1;
      @(posedge CLOCK_50); #1;
      reset = 1'b0;
      @(posedge CLOCK_50); #1;

      // Reference sequence 300, 250, 400
      send(300, 30);
      send(250, 30);
      send(400, 30);
      // Display sweep with zero latency
      exp_sweep[0] = m_last;
      exp_sweep[1] = m_best_valid ? m_best : 0;
      exp_sweep[2] = m_avg;
      exp_sweep[3] = hist_q.size();
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         #1;
         check("sel_sweep", disp_value, exp_sweep[s]);
      end
      sel = 2'd0;
      @(posedge CLOCK_50); #1;

      // Saturation
      send(12000, 30);
      // Equal-to-best must not pulse
      send(250, 30);

      // Eviction: eight 1000s back to back, then 200
      do_clear(1'b0, 0);
      repeat (8) send(1000, 1);
      send(200, 30);

      // Restart: second sample three cycles after the first
      do_clear(1'b0, 0);
      send(500, 3);
      send(100, 30);

      // Clear with a colliding sample during a division
      send(700, 5);
      do_clear(1'b1, 50);
      sel = 2'd1;
      #1;
      check("clear_sel_best", disp_value, 0);
      sel = 2'd0;
      @(posedge CLOCK_50); #1;
      repeat (25) begin
         @(posedge CLOCK_50); #1;
      end

      // Randomised traffic
      for (int k = 0; k < 150; k++) begin
         r = $urandom_range(0, 99);
         if (r < 5) begin
            do_clear(r < 2, $urandom_range(0, 12000));
         end else begin
            if (r < 15 && m_best_valid) t = m_best;
            else if (r < 40)            t = $urandom_range(0, 400);
            else                        t = $urandom_range(0, 12000);
            send(t, $urandom_range(1, 22));
         end
      end

      // Drain outstanding expectations within a bounded wait
      for (int i = 0; i < 200 && (avg_q.size() > 0 || samp_q.size() > 0); i++) begin
         @(posedge CLOCK_50); #1;
      end
      check("drain_avg_q",  avg_q.size(),  0);
      check("drain_samp_q", samp_q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
